// File: rtl/acc_data_fifo.sv
// 128-bit synchronous FIFO between the data & control router and one accelerator.
// Registered read port, registered full/empty flags, sticky overflow/underflow.
module acc_data_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 put_req,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 get_req,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_BITS-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_BITS:0]   count_reg, count_next;
    logic                 full_reg, full_next;
    logic                 empty_reg, empty_next;
    logic                 overflow_reg, overflow_next;
    logic                 underflow_reg, underflow_next;
    logic                 data_valid_reg, data_valid_next;
    logic [WIDTH-1:0]     data_out_reg, data_out_next;

    logic put_ok;
    logic get_ok;

    // Acceptance uses the flags as they stood at the start of the cycle.
    assign put_ok = put_req & ~full_reg & ~flush;
    assign get_ok = get_req & ~empty_reg & ~flush;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        overflow_next   = overflow_reg;
        underflow_next  = underflow_reg;
        data_valid_next = 1'b0;
        data_out_next   = data_out_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (put_ok)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (get_ok) begin
                rd_ptr_next     = rd_ptr_reg + 1'b1;
                data_out_next   = mem[rd_ptr_reg];
                data_valid_next = 1'b1;
            end
            if (put_ok && !get_ok)
                count_next = count_reg + 1'b1;
            else if (get_ok && !put_ok)
                count_next = count_reg - 1'b1;
            if (put_req && full_reg)
                overflow_next = 1'b1;
            if (get_req && empty_reg)
                underflow_next = 1'b1;
        end

        full_next  = (count_next == DEPTH_CNT);
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
            data_out_reg   <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            full_reg       <= full_next;
            empty_reg      <= empty_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
            data_valid_reg <= data_valid_next;
            data_out_reg   <= data_out_next;
        end
    end

    // Storage is not reset; each entry loads only when addressed by an accepted put.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (put_ok && (wr_ptr_reg == ADDR_BITS'(gi)))
                    mem[gi] <= data_in;
            end
        end
    endgenerate

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_acc_data_fifo.sv
// Directed bench for acc_data_fifo: fill/drain, wrap, boundary put+get, flush, async reset.
module tb_acc_data_fifo;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         put_req;
    logic [127:0] data_in;
    logic         get_req;
    logic [127:0] data_out;
    logic         data_valid;
    logic         full;
    logic         empty;
    logic [4:0]   count;
    logic         overflow;
    logic         underflow;

    int total = 0;
    int bad   = 0;

    acc_data_fifo #(.WIDTH(128), .DEPTH(16), .ADDR_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .put_req    (put_req),
        .data_in    (data_in),
        .get_req    (get_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s obs=%0h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set after a negedge; one call advances one rising edge and returns at the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        put_req = 1'b0;
        get_req = 1'b0;
        data_in = '0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_full", 128'(full), 128'd0);
        chk("rst_dout", data_out, 128'd0);
        chk("rst_dvalid", 128'(data_valid), 128'd0);
        chk("rst_ovf", 128'(overflow), 128'd0);
        chk("rst_unf", 128'(underflow), 128'd0);
        reset = 1'b1;

        // Fill with 1..16
        for (int i = 1; i <= 16; i++) begin
            put_req = 1'b1;
            data_in = 128'(i);
            cycle();
            chk("fill_count", 128'(count), 128'(i));
        end
        chk("fill_full", 128'(full), 128'd1);
        chk("fill_empty", 128'(empty), 128'd0);
        data_in = 128'h99;
        cycle();
        chk("p17_ovf", 128'(overflow), 128'd1);
        chk("p17_count", 128'(count), 128'd16);
        put_req = 1'b0;

        // Drain 1..16
        for (int i = 1; i <= 16; i++) begin
            get_req = 1'b1;
            cycle();
            chk("drain_dout", data_out, 128'(i));
            chk("drain_dvalid", 128'(data_valid), 128'd1);
            chk("drain_count", 128'(count), 128'(16 - i));
        end
        get_req = 1'b0;
        cycle();
        chk("drain_dvalid_end", 128'(data_valid), 128'd0);
        chk("drain_empty", 128'(empty), 128'd1);
        chk("drain_dout_hold", data_out, 128'd16);

        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush1_ovf", 128'(overflow), 128'd0);

        // Wrap-around at occupancy 3
        for (int i = 0; i < 3; i++) begin
            put_req = 1'b1;
            data_in = 128'(100 + i);
            cycle();
        end
        chk("wrap_pre_count", 128'(count), 128'd3);
        for (int k = 0; k < 40; k++) begin
            put_req = 1'b1;
            get_req = 1'b1;
            data_in = 128'(103 + k);
            cycle();
            chk("wrap_dout", data_out, 128'(100 + k));
            chk("wrap_count", 128'(count), 128'd3);
        end
        put_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("wrap_tail", data_out, 128'(140 + k));
        end
        get_req = 1'b0;
        cycle();
        chk("wrap_empty", 128'(empty), 128'd1);
        chk("wrap_unf", 128'(underflow), 128'd0);

        // Full: put+get together
        for (int i = 0; i < 16; i++) begin
            put_req = 1'b1;
            data_in = 128'(32'h200 + i);
            cycle();
        end
        chk("bfull_full", 128'(full), 128'd1);
        get_req = 1'b1;
        data_in = 128'h2FF;
        cycle();
        put_req = 1'b0;
        chk("bfull_count", 128'(count), 128'd15);
        chk("bfull_dout", data_out, 128'h200);
        chk("bfull_ovf", 128'(overflow), 128'd1);
        chk("bfull_full_off", 128'(full), 128'd0);
        for (int i = 1; i < 16; i++) begin
            cycle();
            chk("bfull_drain", data_out, 128'(32'h200 + i));
        end
        get_req = 1'b0;
        cycle();
        chk("bfull_empty", 128'(empty), 128'd1);

        flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Empty: put+get together
        put_req = 1'b1;
        get_req = 1'b1;
        data_in = 128'h300;
        cycle();
        put_req = 1'b0;
        get_req = 1'b0;
        chk("bempty_count", 128'(count), 128'd1);
        chk("bempty_dvalid", 128'(data_valid), 128'd0);
        chk("bempty_unf", 128'(underflow), 128'd1);
        chk("bempty_dout_hold", data_out, 128'h20F);
        get_req = 1'b1;
        cycle();
        get_req = 1'b0;
        chk("bempty_pop", data_out, 128'h300);

        // Flush with 5 entries and a concurrent put
        for (int i = 0; i < 5; i++) begin
            put_req = 1'b1;
            data_in = 128'(32'h400 + i);
            cycle();
        end
        chk("flush_pre_count", 128'(count), 128'd5);
        flush   = 1'b1;
        data_in = 128'h4FF;
        cycle();
        flush   = 1'b0;
        put_req = 1'b0;
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_empty", 128'(empty), 128'd1);
        chk("flush_unf", 128'(underflow), 128'd0);
        chk("flush_ovf", 128'(overflow), 128'd0);
        chk("flush_dout", data_out, 128'h300);
        chk("flush_dvalid", 128'(data_valid), 128'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 8; i++) begin
            put_req = 1'b1;
            data_in = 128'(32'h600 + i);
            cycle();
        end
        put_req = 1'b0;
        chk("areset_pre_count", 128'(count), 128'd8);
        get_req = 1'b1;
        @(posedge clk);
        #2;
        chk("areset_pre_dout", data_out, 128'h600);
        reset = 1'b0;
        #1;
        chk("areset_dout", data_out, 128'd0);
        chk("areset_dvalid", 128'(data_valid), 128'd0);
        chk("areset_count", 128'(count), 128'd0);
        chk("areset_empty", 128'(empty), 128'd1);
        get_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        put_req = 1'b1;
        data_in = 128'h700;
        cycle();
        put_req = 1'b0;
        chk("post_count", 128'(count), 128'd1);
        get_req = 1'b1;
        cycle();
        get_req = 1'b0;
        chk("post_dout", data_out, 128'h700);
        chk("post_dvalid", 128'(data_valid), 128'd1);
        cycle();
        chk("post_empty", 128'(empty), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_data_fifo.md
# acc_data_fifo

Synchronous 128-bit FIFO that buffers data between the data & control router and one accelerator (FFT, FIR or IIR). One instance sits on each path: router-to-accelerator, where the router pushes and the accelerator pops, and accelerator-to-router, where the accelerator pushes and the router pops. Its `full`/`empty` flags are the signals the router uses to pause address generation. It also tracks occupancy and reports protocol errors.

## Interface

- `WIDTH`, 128, data word width in bits
- `DEPTH`, 16, number of entries; must be a power of 2, at least 2
- `ADDR_BITS`, 4, log2(`DEPTH`)

- `clk`  in  1  system clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `flush`  in  1  synchronous clear of pointers, count and error flags
- `put_req`  in  1  write request
- `data_in`  in  `WIDTH`  write data, sampled with `put_req`
- `get_req`  in  1  read request
- `data_out`  out  `WIDTH`  read data, registered
- `data_valid`  out  1  one-cycle pulse: `data_out` holds a newly popped word
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `count`  out  `ADDR_BITS+1`  current occupancy, 0..`DEPTH`
- `overflow`  out  1  sticky: a put was attempted while full
- `underflow`  out  1  sticky: a get was attempted while empty

## Operation

- Storage is a `DEPTH` x `WIDTH` register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are `ADDR_BITS` wide.
  - Both wrap modulo `DEPTH` by natural overflow; there is no special wrap logic.
- Put accepted: `put_req & !full`.
  - Stores `mem[wr_ptr] <= data_in` and increments `wr_ptr`.
- Get accepted: `get_req & !empty`.
  - Loads `data_out <= mem[rd_ptr]`, increments `rd_ptr` and sets `data_valid <= 1`.
- Count update each cycle:
  - +1 on a put only.
  - −1 on a get only.
  - Unchanged when both are accepted or neither is.
- `full` and `empty` are registered and derived from the next-state count, so they are always consistent with `count`.
- Rejected put (`put_req & full`):
  - Memory and pointers are unchanged.
  - `overflow <= 1`.
- Rejected get (`get_req & empty`):
  - `data_out` holds its value and `data_valid <= 0`.
  - `underflow <= 1`.
- Simultaneous put and get:
  - Not full and not empty: both are accepted and `count` is unchanged.
  - Full: the get is accepted and the put is rejected, because acceptance uses the flag at the start of the cycle. `overflow` is set.
  - Empty: the put is accepted and the get is rejected. `underflow` is set. There is no fall-through.
- `flush` has priority over `put_req` and `get_req` in the same cycle.
  - Cleared: pointers, `count`, `overflow`, `underflow`, `data_valid`.
  - Set: `empty <= 1`, `full <= 0`.
  - Unchanged: memory contents and `data_out`.
- Reset, asserted at any time including mid-transfer, forces every output to its reset value immediately and asynchronously. Memory contents are not reset.

## Timing

- Reset values:
  - `data_out = 0`, `data_valid = 0`, `full = 0`, `empty = 1`, `count = 0`, `overflow = 0`, `underflow = 0`
  - `wr_ptr = 0`, `rd_ptr = 0`
- Write-to-flag latency: a put accepted at edge N makes `empty` deassert and `count` increment after edge N.
- Read latency is 1 cycle: a get accepted at edge N presents `data_out` and a `data_valid` pulse after edge N.
- Write-to-read latency:
  - The earliest a word written at edge N can be popped is edge N+1.
  - It appears on `data_out` after edge N+1.
- Throughput: one put and one get per cycle, sustained indefinitely when occupancy is between 1 and `DEPTH`−1.
- `data_valid` is high for exactly one cycle per accepted get. Back-to-back gets hold it high continuously.
- Flag timing for requesters: `full` and `empty` are valid at the start of each cycle. Requesters gate `put_req`/`get_req` combinationally on these flags.
- Reset deassertion: the first accepted operation is at the first rising edge after `reset` goes high.

## Test plan

- **Reset:** hold `reset = 0` for 3 cycles, then release → all outputs at their reset values; `empty = 1`, `count = 0`.
- **Fill and drain:** put 16 words `0x1..0x10`.
  - Expect `count = 16` and `full = 1`; a 17th put sets `overflow = 1` with `count` still 16.
  - Then get 16 times: expect `data_out = 0x1..0x10` in order, each 1 cycle after its get, with `data_valid` high for 16 cycles; `empty = 1` after the last.
- **Wrap-around:** run 40 interleaved put/get pairs at occupancy 3 → all 40 words return in order and `count` stays at 3 throughout.
- **Simultaneous at boundaries:**
  - FIFO full, put+get together: `count` goes 16→15, the popped word is the oldest, and `overflow = 1`.
  - FIFO empty, put+get together: `count` goes 0→1, `data_valid = 0`, and `underflow = 1`.
- **Flush:** with 5 entries, assert `flush` together with `put_req` → `count = 0`, `empty = 1`, errors cleared, the put is ignored, and `data_out` is unchanged.
- **Asynchronous reset mid-operation:** assert `reset` between edges while 8 entries are held and a get is in flight → outputs clear immediately without waiting for an edge; the next put/get sequence behaves as it does from a fresh reset.
